// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: priority resolution, INTA handshake, ISR and EOI handling.
// Define PIC_ROTATE_PRIORITY_EN for rotating priority; the default build uses fixed priority with IR0 highest.
module interrupt_ack_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic       interrupt_acknowledge_n,
  input  logic       end_of_interrupt,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  input  logic       auto_eoi_config,
  input  logic [4:0] vector_base,
  output logic       interrupt,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

  state_t     state, state_next;
  logic       inta_prev, inta_fall, inta_rise;
  logic [2:0] level, level_next;
  logic       spurious, spurious_next;
  logic       interrupt_next;
  logic [7:0] clear_next, isr_set, isr_clr, eligible;
  logic [3:0] winner, isr_top;  // {found, level}
  logic       outranks;

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [2:0] pointer;
`else
  // A constant lowest-priority level of 7 folds the search into plain IR0-first priority.
  localparam logic [2:0] pointer = 3'd7;
`endif

  function automatic logic [3:0] highest(input logic [7:0] v, input logic [2:0] ptr);
    logic [3:0] r;
    logic [2:0] lvl;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      lvl = ptr + 3'd1 + i[2:0];
      if (!r[3] && v[lvl]) r = {1'b1, lvl};
    end
    return r;
  endfunction

  // Position in the current priority order; 0 is the highest.
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] ptr);
    return lvl - ptr - 3'd1;
  endfunction

  assign eligible     = interrupt_request_register & ~interrupt_mask;
  assign winner       = highest(eligible, pointer);
  assign isr_top      = highest(in_service_register, pointer);
  assign outranks     = winner[3] &&
                        (!isr_top[3] || (rank(winner[2:0], pointer) < rank(isr_top[2:0], pointer)));
  assign inta_fall    = inta_prev & ~interrupt_acknowledge_n;
  assign inta_rise    = ~inta_prev & interrupt_acknowledge_n;
  assign freeze       = (state != IDLE);
  assign vector_valid = (state == ACK2) && !interrupt_acknowledge_n;
  assign vector_out   = {vector_base, level};

  always_comb begin
    state_next     = state;
    level_next     = level;
    spurious_next  = spurious;
    interrupt_next = outranks;
    clear_next     = '0;
    isr_set        = '0;
    isr_clr        = '0;

    if (end_of_interrupt) begin
      if (specific_eoi)    isr_clr[eoi_level]    = 1'b1;
      else if (isr_top[3]) isr_clr[isr_top[2:0]] = 1'b1;
    end

    unique case (state)
      IDLE: if (inta_fall) begin
        state_next     = ACK1;
        interrupt_next = 1'b0;
        if (winner[3]) begin
          level_next             = winner[2:0];
          spurious_next          = 1'b0;
          isr_set[winner[2:0]]   = 1'b1;
          clear_next[winner[2:0]] = 1'b1;
        end else begin
          level_next    = 3'd7;
          spurious_next = 1'b1;
        end
      end
      ACK1: if (inta_fall) state_next = ACK2;
      ACK2: if (inta_rise) begin
        state_next = IDLE;
        if (auto_eoi_config && !spurious) isr_clr[level] = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      inta_prev               <= 1'b1;
      level                   <= '0;
      spurious                <= 1'b0;
      interrupt               <= 1'b0;
      clear_interrupt_request <= '0;
      in_service_register     <= '0;
    end else begin
      state                   <= state_next;
      inta_prev               <= interrupt_acknowledge_n;
      level                   <= level_next;
      spurious                <= spurious_next;
      interrupt               <= interrupt_next;
      clear_interrupt_request <= clear_next;
      // A set in the same cycle as a clear of the same bit wins.
      in_service_register     <= (in_service_register & ~isr_clr) | isr_set;
    end
  end

`ifdef PIC_ROTATE_PRIORITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pointer <= 3'd7;
    else if (state == ACK2 && inta_rise && auto_eoi_config && !spurious)
      pointer <= level;
    else if (end_of_interrupt && !specific_eoi && isr_top[3])
      pointer <= isr_top[2:0];
  end
`endif

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       inta_n, eoi, spec, aeoi;
  logic [2:0] eoi_lvl;
  logic [4:0] vbase;
  logic       interrupt, freeze, vector_valid;
  logic [7:0] clear_irr, isr, vector_out;

  int n_vec  = 0;
  int n_fail = 0;

  interrupt_ack_sequencer dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_request_register (irr),
    .interrupt_mask             (imr),
    .interrupt_acknowledge_n    (inta_n),
    .end_of_interrupt           (eoi),
    .specific_eoi               (spec),
    .eoi_level                  (eoi_lvl),
    .auto_eoi_config            (aeoi),
    .vector_base                (vbase),
    .interrupt                  (interrupt),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_irr),
    .in_service_register        (isr),
    .vector_out                 (vector_out),
    .vector_valid               (vector_valid)
  );

  always #5 clock = ~clock;

  // Behavioural model: phase 0 = idle, 1 = first INTA seen, 2 = vector phase.
  logic [7:0] m_isr, m_clr;
  logic [2:0] m_lvl;
  int         m_phase, m_ptr;
  bit         m_spur, m_prev, m_int;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rank(input int l, input int p);
    return (l - p + 15) % 8;
  endfunction

  function automatic int top(input logic [7:0] v, input int p);
    int best, br;
    best = -1;
    br   = 99;
    for (int l = 0; l < 8; l++)
      if (v[l] && rank(l, p) < br) begin
        br   = rank(l, p);
        best = l;
      end
    return best;
  endfunction

  task automatic model_reset();
    m_isr = '0; m_clr = '0; m_lvl = '0; m_phase = 0; m_ptr = 7;
    m_spur = 0; m_prev = 1; m_int = 0;
  endtask

  task automatic model_step();
    int w, h;
    logic [7:0] nisr;
    bit fall, rise;
    w    = top(irr & ~imr, m_ptr);
    h    = top(m_isr, m_ptr);
    fall = m_prev && !inta_n;
    rise = !m_prev && inta_n;
    nisr = m_isr;
    m_int = (w >= 0) && (h < 0 || rank(w, m_ptr) < rank(h, m_ptr));
    m_clr = '0;
    if (eoi) begin
      if (spec) nisr[eoi_lvl] = 1'b0;
      else if (h >= 0) begin
        nisr[3'(h)] = 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
        m_ptr = h;
`endif
      end
    end
    case (m_phase)
      0: if (fall) begin
        m_phase = 1;
        m_int   = 0;
        if (w >= 0) begin
          m_lvl = 3'(w); nisr[3'(w)] = 1'b1; m_clr = 8'(1 << w); m_spur = 0;
        end else begin
          m_lvl = 3'd7; m_spur = 1;
        end
      end
      1: if (fall) m_phase = 2;
      default: if (rise) begin
        m_phase = 0;
        if (aeoi && !m_spur) begin
          nisr[m_lvl] = 1'b0;
`ifdef PIC_ROTATE_PRIORITY_EN
          m_ptr = int'(m_lvl);
`endif
        end
      end
    endcase
    m_isr  = nisr;
    m_prev = inta_n;
  endtask

  always @(negedge clock) begin
    if (reset) model_reset();
    check("interrupt",    {7'b0, interrupt},    {7'b0, m_int});
    check("freeze",       {7'b0, freeze},       {7'b0, m_phase != 0});
    check("clear_irr",    clear_irr,            m_clr);
    check("isr",          isr,                  m_isr);
    check("vector_out",   vector_out,           {vbase, m_lvl});
    check("vector_valid", {7'b0, vector_valid}, {7'b0, (m_phase == 2) && !inta_n});
    if (!reset) model_step();
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ack();
    inta_n = 0; tick();
    inta_n = 1; tick();
    inta_n = 0; tick();
    inta_n = 1; tick();
  endtask

  task automatic reset_pulse();
    inta_n = 1; eoi = 0; spec = 0; aeoi = 0; irr = '0; imr = '0;
    reset = 1; tick();
    reset = 0; tick();
  endtask

  initial begin
    reset = 1; irr = '0; imr = '0; inta_n = 1; eoi = 0; spec = 0;
    eoi_lvl = '0; aeoi = 0; vbase = 5'h08;
    repeat (3) tick();
    check("rst_isr",    isr,               8'h00);
    check("rst_vector", vector_out,        8'h40);
    check("rst_freeze", {7'b0, freeze},    8'h00);
    check("rst_int",    {7'b0, interrupt}, 8'h00);
    reset = 0; tick();

    // Basic acknowledge
    irr = 8'h24; tick();
    check("basic_int", {7'b0, interrupt}, 8'h01);
    inta_n = 0; tick();
    check("basic_isr",    isr,            8'h04);
    check("basic_clr",    clear_irr,      8'h04);
    check("basic_freeze", {7'b0, freeze}, 8'h01);
    irr = 8'h20; inta_n = 1; tick();
    check("basic_clr_once", clear_irr, 8'h00);
    inta_n = 0; tick();
    check("basic_vec",   vector_out,           8'h42);
    check("basic_valid", {7'b0, vector_valid}, 8'h01);
    inta_n = 1; tick();
    check("basic_release", {7'b0, freeze}, 8'h00);
    reset_pulse();

    // Masking and nesting
    imr = 8'h04; irr = 8'h24; tick();
    ack();
    check("nest_isr", isr, 8'h20);
    irr = 8'h40; tick(); tick();
    check("nest_low_int", {7'b0, interrupt}, 8'h00);
    irr = 8'h01; tick();
    check("nest_high_int", {7'b0, interrupt}, 8'h01);
    reset_pulse();

    // Spurious acknowledge
    inta_n = 0; tick();
    check("spur_clr", clear_irr, 8'h00);
    check("spur_isr", isr,       8'h00);
    inta_n = 1; tick();
    inta_n = 0; tick();
    check("spur_vec",   vector_out,           8'h47);
    check("spur_valid", {7'b0, vector_valid}, 8'h01);
    inta_n = 1; tick();
    reset_pulse();

    // Automatic EOI
    aeoi = 1; irr = 8'h08; tick();
    inta_n = 0; tick();
    check("aeoi_isr_ack1", isr, 8'h08);
    irr = 8'h00; inta_n = 1; tick();
    inta_n = 0; tick();
    check("aeoi_isr_ack2", isr, 8'h08);
    inta_n = 1; tick();
    check("aeoi_isr_done", isr, 8'h00);
    reset_pulse();

    // EOI forms on ISR = 0x0A
    irr = 8'h08; tick(); ack();
    irr = 8'h02; tick(); ack();
    check("eoi_isr_start", isr, 8'h0A);
    irr = 8'h00; eoi = 1; spec = 0; tick();
    check("eoi_nonspecific", isr, 8'h08);
    spec = 1; eoi_lvl = 3'd3; tick();
    check("eoi_specific", isr, 8'h00);
    eoi = 0; spec = 0; tick();
    reset_pulse();

    // Reset in ACK1
    irr = 8'h10; tick();
    inta_n = 0; tick();
    check("abort_freeze_pre", {7'b0, freeze}, 8'h01);
    #1 reset = 1;
    #1;
    check("abort_freeze", {7'b0, freeze}, 8'h00);
    check("abort_isr",    isr,            8'h00);
    inta_n = 1; tick();
    reset = 0; tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irr     = 8'($urandom);
      imr     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      eoi     = ($urandom_range(0, 5) == 0);
      spec    = 1'($urandom_range(0, 1));
      eoi_lvl = 3'($urandom);
      aeoi    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) vbase = 5'($urandom);
      reset   = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; inta_n = 1; eoi = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
